// File: rtl/dcs_out_requant.sv
// dcs_out_requant: collects eight 32-bit result words from the attention core,
// derives a shared block shift from the block maximum, and streams the eight
// words back out as 8-bit values with a valid/ready handshake.
// Optional build macro: DCS_REQ_ROUND_EN selects round-half-up with saturation
// instead of plain truncation when requantizing.
module dcs_out_requant (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [2:0]  out_idx,
    output logic        out_last,
    output logic [4:0]  out_shift,
    output logic [2:0]  argmax,
    output logic        busy,
    output logic        drop_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCALE   = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Block storage; contents are only meaningful between COLLECT and EMIT,
    // so it carries no reset.
    logic [31:0] word_buf_q [8];

    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] max_q, max_d;
    logic [2:0]  argmax_q, argmax_d;
    logic [4:0]  shift_q, shift_d;
    logic        drop_q, drop_d;

    logic        store;
    logic [2:0]  wr_idx;
    logic        handshake;
    logic [4:0]  msb_pos;
    logic [4:0]  scale_shift;
    logic [31:0] rd_word;
    logic [7:0]  req_word;

    // A word is accepted only while filling; IDLE always restarts at slot 0.
    assign store     = in_valid && ((state_q == IDLE) || (state_q == COLLECT));
    assign wr_idx    = (state_q == IDLE) ? 3'd0 : cnt_q;
    assign handshake = (state_q == EMIT) && out_ready;
    assign rd_word   = word_buf_q[k_q];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fill 8 words, one scale cycle, then 8 handshakes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = COLLECT;
            COLLECT: if (in_valid && (cnt_q == 3'd7)) state_d = SCALE;
            SCALE:   state_d = EMIT;
            EMIT:    if (out_ready && (k_q == 3'd7)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write accepted words into the block buffer.
    always_ff @(posedge clk) begin
        if (store) begin
            word_buf_q[wr_idx] <= in_data;
        end
    end

    // Position of the highest set bit of the block maximum.
    always_comb begin
        msb_pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (max_q[i]) msb_pos = 5'(i);
        end
    end

    // Shift so the maximum lands in the top bit of an 8-bit result.
    assign scale_shift = (max_q < 32'd256) ? 5'd0 : (msb_pos - 5'd7);

    // Datapath next-state: counters, running max (strictly greater wins, so
    // ties keep the lowest index), block shift and the sticky drop flag.
    always_comb begin
        cnt_d    = cnt_q;
        k_d      = k_q;
        max_d    = max_q;
        argmax_d = argmax_q;
        shift_d  = shift_q;
        drop_d   = drop_q;
        if (store) begin
            cnt_d = wr_idx + 3'd1;
            if ((state_q == IDLE) || (in_data > max_q)) begin
                max_d    = in_data;
                argmax_d = wr_idx;
            end
        end
        if (state_q == SCALE) begin
            shift_d = scale_shift;
        end
        if (handshake) begin
            k_d = k_q + 3'd1;
        end
        if (in_valid && ((state_q == SCALE) || (state_q == EMIT))) begin
            drop_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 3'd0;
            k_q      <= 3'd0;
            max_q    <= 32'd0;
            argmax_q <= 3'd0;
            shift_q  <= 5'd0;
            drop_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            max_q    <= max_d;
            argmax_q <= argmax_d;
            shift_q  <= shift_d;
            drop_q   <= drop_d;
        end
    end

`ifdef DCS_REQ_ROUND_EN
    logic [32:0] round_sum;
    logic [32:0] round_shifted;

    // Round half up, then clamp: rounding can carry the maximum to 256.
    always_comb begin
        round_sum     = 33'd0;
        round_shifted = 33'd0;
        req_word      = 8'(rd_word);
        if (shift_q != 5'd0) begin
            round_sum     = {1'b0, rd_word} + (33'd1 << (shift_q - 5'd1));
            round_shifted = round_sum >> shift_q;
            req_word      = (round_shifted > 33'd255) ? 8'hFF : 8'(round_shifted);
        end
    end
`else
    // Truncating requantization; the shift guarantees every word fits 8 bits.
    always_comb begin
        req_word = 8'(rd_word >> shift_q);
    end
`endif

    // Output logic: everything except busy/drop_err is quiet outside EMIT.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'd0;
        out_idx   = 3'd0;
        out_last  = 1'b0;
        out_shift = 5'd0;
        argmax    = 3'd0;
        busy      = (state_q != IDLE);
        drop_err  = drop_q;
        if (state_q == EMIT) begin
            out_valid = 1'b1;
            out_data  = req_word;
            out_idx   = k_q;
            out_last  = (k_q == 3'd7);
            out_shift = shift_q;
            argmax    = argmax_q;
        end
    end

endmodule
